// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential signed shift-add multiplier (sign-magnitude datapath)
// Optional feature: define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load_data,
  input  logic                 shift_en,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 product_neg,
  output logic                 mult_done,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic [WIDTH-1:0]     r_mplier;
  logic [CW-1:0]        r_cnt;
  logic                 r_sign;
  logic                 r_product_neg;

  logic                 w_reset;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_mplier_next;
  logic [CW-1:0]        w_cnt_next;
  logic                 w_last;
  logic                 w_step;
  logic [2*WIDTH-1:0]   w_result;

  assign w_reset = rst | clr;

  // Subtracting from zero in WIDTH bits maps the most-negative value onto 2^(WIDTH-1) unsigned.
  assign w_a_mag = multiplicand[WIDTH-1] ? ({WIDTH{1'b0}} - multiplicand) : multiplicand;
  assign w_b_mag = multiplier[WIDTH-1]   ? ({WIDTH{1'b0}} - multiplier)   : multiplier;

  assign w_step        = (r_state == S_RUN) && shift_en && !load_data;
  assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_next = r_mplier >> 1;
  assign w_cnt_next    = r_cnt + CW'(1);

`ifdef MULT_EARLY_TERM_EN
  assign w_last = (w_cnt_next == CW'(WIDTH)) || (w_mplier_next == {WIDTH{1'b0}});
`else
  assign w_last = (w_cnt_next == CW'(WIDTH));
`endif

  assign w_result = r_sign ? ({(2*WIDTH){1'b0}} - w_acc_next) : w_acc_next;

  // State register.
  always_ff @(posedge clk) begin
    if (w_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status outputs; a load restarts from any state.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    mult_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_data) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (load_data) begin
          w_state_next = S_RUN;
        end else if (shift_en && w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        mult_done = 1'b1;
        if (load_data) w_state_next = S_RUN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture on load, one shift-add per enabled RUN cycle, result on the last step.
  always_ff @(posedge clk) begin
    if (w_reset) begin
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_sign        <= 1'b0;
      r_product     <= '0;
      r_product_neg <= 1'b0;
    end else if (load_data) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign   <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
    end else if (w_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_next;
      r_cnt    <= w_cnt_next;
      if (w_last) begin
        r_product     <= w_result;
        r_product_neg <= r_sign && (w_acc_next != {(2*WIDTH){1'b0}});
      end
    end
  end

  assign product     = r_product;
  assign product_neg = r_product_neg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier
module tb_shift_add_multiplier;

  localparam int W = 8;
`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, clr, load_data, shift_en;
  logic [W-1:0]  a, b;
  logic [2*W-1:0] product;
  logic          product_neg, mult_done, busy;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .load_data    (load_data),
    .shift_en     (shift_en),
    .multiplicand (a),
    .multiplier   (b),
    .product      (product),
    .product_neg  (product_neg),
    .mult_done    (mult_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    logic           n;
    int             lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   t_load   = 0;
  logic mon_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rising mult_done consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mult_done && !mon_prev) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got mult_done=1 expected no result pending");
        end else begin
          e = sb_q.pop_front();
          check("product", product, e.p);
          check("product_neg", product_neg, e.n);
          check("latency", cyc - t_load, e.lat);
        end
      end
      mon_prev = mult_done;
    end
  end

  task automatic run_vec(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [2*W-1:0] ep, input logic en,
                         input int lat_full, input int lat_early,
                         input int stall_after, input int stall_len);
    exp_t e;
    bit   got;
    e.p   = ep;
    e.n   = en;
    e.lat = EARLY ? lat_early : lat_full;
    @(negedge clk);
    a = va; b = vb; load_data = 1'b1; shift_en = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    t_load    = cyc;
    load_data = 1'b0;
    check("busy_after_load", busy, 1);
    if (stall_len > 0) begin
      repeat (stall_after) @(posedge clk);
      #1 shift_en = 1'b0;
      repeat (stall_len) @(posedge clk);
      #1;
      check("busy_in_stall", busy, 1);
      shift_en = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (mult_done) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no mult_done expected one within 40 cycles");
      void'(sb_q.pop_back());
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      shift_en = ~shift_en;
    end
    @(negedge clk);
    check("hold_product", product, ep);
    check("hold_done", mult_done, 1);
    check("hold_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; load_data = 1'b0; shift_en = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_product", product, 0);
    check("rst_neg", product_neg, 0);
    check("rst_done", mult_done, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // shift_en in IDLE must not start anything
    shift_en = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", mult_done, 0);

    run_vec(8'h03, 8'h05, 16'h000F, 1'b0, 8, 3, 0, 0);
    run_vec(8'hF9, 8'h06, 16'hFFD6, 1'b1, 8, 3, 0, 0);
    run_vec(8'h80, 8'h80, 16'h4000, 1'b0, 8, 8, 0, 0);
    run_vec(8'h00, 8'hFB, 16'h0000, 1'b0, 8, 3, 0, 0);
    run_vec(8'hFB, 8'h00, 16'h0000, 1'b0, 8, 1, 0, 0);
    run_vec(8'h0C, 8'h0A, 16'h0078, 1'b0, 11, 7, 2, 3);

    // restart mid-RUN: 9*9 partially computed, then 2*3 takes over
    @(negedge clk);
    a = 8'h09; b = 8'h09; load_data = 1'b1; shift_en = 1'b1;
    @(posedge clk); #1 load_data = 1'b0;
    repeat (EARLY ? 3 : 4) @(posedge clk);
    run_vec(8'h02, 8'h03, 16'h0006, 1'b0, 8, 2, 0, 0);

    run_vec(8'h05, 8'h01, 16'h0005, 1'b0, 8, 1, 0, 0);
    run_vec(8'hFF, 8'hFF, 16'h0001, 1'b0, 8, 1, 0, 0);
    run_vec(8'h07, 8'hFF, 16'hFFF9, 1'b1, 8, 1, 0, 0);
    run_vec(8'h7F, 8'h80, 16'hC080, 1'b1, 8, 8, 0, 0);

    // rst mid-RUN clears outputs and suppresses the result
    @(negedge clk);
    a = 8'h09; b = 8'h09; load_data = 1'b1; shift_en = 1'b1;
    @(posedge clk); #1 load_data = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", mult_done, 0);
    check("abort_product", product, 0);
    check("abort_neg", product_neg, 0);
    repeat (12) @(negedge clk);
    check("abort_idle_busy", busy, 0);
    check("abort_idle_done", mult_done, 0);

    // clr while holding a result
    run_vec(8'h07, 8'hFF, 16'hFFF9, 1'b1, 8, 1, 0, 0);
    @(negedge clk) clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    check("clr_product", product, 0);
    check("clr_neg", product_neg, 0);
    check("clr_done", mult_done, 0);
    check("clr_busy", busy, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; product width is 2*WIDTH.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port clr  input  1  synchronous clear, active-high; same effect as rst.
REQ-005 SHALL have port load_data  input  1  capture operands and start a new multiplication.
REQ-006 SHALL have port shift_en  input  1  permit one shift-add step this cycle.
REQ-007 SHALL have port multiplicand  input  WIDTH  signed two's-complement operand A.
REQ-008 SHALL have port multiplier  input  WIDTH  signed two's-complement operand B.
REQ-009 SHALL have port product  output  2*WIDTH  signed two's-complement result A*B.
REQ-010 SHALL have port product_neg  output  1  sign of the result, for the display sign digit.
REQ-011 SHALL have port mult_done  output  1  level; result valid.
REQ-012 SHALL have port busy  output  1  level; multiplication in progress.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE; busy=1 only in RUN; mult_done=1 only in DONE.
REQ-014 SHALL, on load_data=1 in any state, register |A| and |B| as WIDTH-bit unsigned magnitudes, register sign=A[msb]^B[msb], clear the 2*WIDTH accumulator and step counter, and enter RUN next cycle.
REQ-015 SHALL compute magnitudes so that the most-negative operand (-2^(WIDTH-1)) yields 2^(WIDTH-1) without overflow.
REQ-016 SHALL, in RUN with shift_en=1 and load_data=0, perform one step per cycle: add the shifted multiplicand to the accumulator if the multiplier LSB is 1, shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter.
REQ-017 SHALL hold all datapath registers unchanged in RUN while shift_en=0 (stall, no timeout).
REQ-018 SHALL, on the step that makes the counter equal WIDTH, enter DONE and, on the same edge, load product with the accumulator result, negated if sign=1.
REQ-019 SHALL give latency: load_data sampled at edge N with shift_en held high -> mult_done and product valid after edge N+WIDTH.
REQ-020 SHALL hold product, product_neg and mult_done=1 in DONE until load_data, rst or clr.
REQ-021 SHALL restart on load_data asserted during RUN, discarding the partial result (load takes priority over shift_en).
REQ-022 SHALL drive product_neg=sign in DONE, but force product_neg=0 when the product is zero.
REQ-023 SHALL keep product and product_neg unchanged while in IDLE or RUN; they update only on entry to DONE.
REQ-024 SHALL ignore shift_en in IDLE and DONE.

Reset
REQ-025 SHALL, on rst=1 or clr=1 at a clock edge, enter IDLE and zero product, product_neg, mult_done, busy, accumulator, counter and operand registers; rst/clr take priority over load_data.
REQ-026 SHALL abort any RUN in progress on rst or clr, with no mult_done pulse.

Configuration
REQ-027 SHALL recognise macro MULT_EARLY_TERM_EN; when defined, a RUN step whose post-shift multiplier register is zero SHALL be the final step (enter DONE as in REQ-018), so latency equals 1 + index of the highest set bit of |B| (1 step when B=0).
REQ-028 SHALL, when MULT_EARLY_TERM_EN is undefined, always take exactly WIDTH steps regardless of operand values.

Verification
REQ-029 SHALL pass: A=3, B=5, load then shift_en high -> mult_done after 8 steps, product=0x000F, product_neg=0.
REQ-030 SHALL pass: A=-7 (0xF9), B=6 -> product=0xFFD6 (-42), product_neg=1; A=-128, B=-128 -> product=0x4000, product_neg=0.
REQ-031 SHALL pass: A=0, B=-5 -> product=0x0000, product_neg=0; A=12, B=10 with shift_en low for 3 cycles mid-RUN -> mult_done 3 cycles later, product=0x0078.
REQ-032 SHALL pass: A=9, B=9, load, 4 steps, then load A=2, B=3 -> after 8 further steps product=0x0006; rst pulsed mid-RUN -> IDLE, all outputs 0, no mult_done.
REQ-033 SHALL pass, with MULT_EARLY_TERM_EN: A=5, B=1 -> mult_done after 1 step, product=0x0005; without the macro the same case takes 8 steps.
